// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_D_BUSY  = 2'd2
  } arb_state_e;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// BUSY-cycle watchdog for the arbiter, instantiated only when ARB_TIMEOUT_EN is defined.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic mem_ack,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count_q <= '0;
    end else if (busy && !mem_ack && !expire) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A coincident mem_ack always takes priority over expiry.
  assign expire = busy && !mem_ack && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch (IF) and load/store (D).
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that aborts with bus_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err,
  output logic                  cpu_stall
);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_cs_d, mem_we_d, if_ack_d, d_ack_d, bus_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, if_rdata_d, d_rdata_d, done_rdata;
  logic                  if_pend, d_pend, grant_if, grant_d, done, abort;

  // A requester being acked this cycle still shows its old req level.
  assign if_pend  = if_req & ~if_ack;
  assign d_pend   = d_req & ~d_ack;
  assign grant_d  = (state_q == ARB_IDLE) && d_pend && (!if_pend || last_grant_q == GRANT_IF);
  assign grant_if = (state_q == ARB_IDLE) && if_pend && !grant_d;

`ifdef ARB_TIMEOUT_EN
  logic expire;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (grant_if | grant_d),
    .busy    (state_q != ARB_IDLE),
    .mem_ack (mem_ack),
    .expire  (expire)
  );

  assign done  = mem_ack | expire;
  assign abort = expire;
`else
  assign done  = mem_ack;
  assign abort = 1'b0;
`endif

  assign done_rdata = abort ? '0 : mem_rdata;
  assign cpu_stall  = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_IF;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_cs       <= mem_cs_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      if_rdata     <= if_rdata_d;
      d_rdata      <= d_rdata_d;
      if_ack       <= if_ack_d;
      d_ack        <= d_ack_d;
      bus_err      <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d      = ARB_D_BUSY;
          last_grant_d = GRANT_D;
        end else if (grant_if) begin
          state_d      = ARB_IF_BUSY;
          last_grant_d = GRANT_IF;
        end
      end
      ARB_IF_BUSY, ARB_D_BUSY: begin
        if (done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_cs_d    = mem_cs;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          mem_cs_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_if) begin
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      ARB_IF_BUSY: begin
        if (done) begin
          mem_cs_d   = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = done_rdata;
          if_ack_d   = 1'b1;
          bus_err_d  = abort;
        end
      end
      ARB_D_BUSY: begin
        if (done) begin
          mem_cs_d  = 1'b0;
          mem_we_d  = 1'b0;
          d_ack_d   = 1'b1;
          bus_err_d = abort;
          // Stores keep the last load data unless the access was aborted.
          if (!mem_we || abort) d_rdata_d = done_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
